// File: rtl/frame_buffer_writer.sv
// Streams AXI-Stream video lines into round-robin frame buffers, one burst per line.
// Optional reader-lock skipping is enabled with FRAME_BUFFER_WRITER_LOCK_EN.
module frame_buffer_writer #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_BUFFERS = 3,
    parameter int MAX_WIDTH   = 1280,
    parameter int MAX_HEIGHT  = 720
) (
    input  logic                           clk,
    input  logic                           rst,
`ifdef FRAME_BUFFER_WRITER_LOCK_EN
    input  logic                           rd_lock_valid,
    input  logic [$clog2(NUM_BUFFERS)-1:0] rd_lock_idx,
`endif
    input  logic [15:0]                    frame_width,
    input  logic [15:0]                    frame_height,
    input  logic [ADDR_WIDTH-1:0]          buffer_base,
    input  logic [ADDR_WIDTH-1:0]          buffer_stride,
    input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tlast,
    input  logic                           s_axis_tuser,
    output logic                           s_axis_tready,
    output logic                           wr_start,
    output logic [ADDR_WIDTH-1:0]          wr_addr,
    output logic [15:0]                    wr_len,
    output logic [DATA_WIDTH-1:0]          wr_data,
    output logic [DATA_WIDTH/8-1:0]        wr_strb,
    output logic                           wr_valid,
    output logic                           wr_last,
    input  logic                           wr_ready,
    output logic                           frame_ready,
    output logic [$clog2(NUM_BUFFERS)-1:0] frame_idx,
    output logic [ADDR_WIDTH-1:0]          frame_base_addr,
    output logic                           err_short_line,
    output logic                           err_long_line,
    output logic                           err_sof
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(NUM_BUFFERS);
    localparam int BEAT_W = $clog2(MAX_WIDTH + 1);
    localparam int LINE_W = $clog2(MAX_HEIGHT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LINE_START, S_STREAM, S_PAD, S_DROP, S_LINE_END, S_DONE
    } state_t;

    state_t                  state, state_n;
    logic [IDX_W-1:0]        idx, idx_n;
    logic [BEAT_W-1:0]       beat, beat_n;
    logic [LINE_W-1:0]       line, line_n;
    logic [15:0]             w_lat, w_n;
    logic [15:0]             h_lat, h_n;
    logic [ADDR_WIDTH-1:0]   line_addr, addr_n;
    logic [ADDR_WIDTH-1:0]   buf_base;
    logic [ADDR_WIDTH-1:0]   line_step;
    logic                    last_beat;
    logic                    last_line;
    logic                    sof_seen;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(NUM_BUFFERS - 1)) return '0;
        return i + 1'b1;
    endfunction

    // Round-robin advance; with the lock feature the reader's buffer is skipped.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        logic [IDX_W-1:0] n;
        n = wrap_inc(i);
`ifdef FRAME_BUFFER_WRITER_LOCK_EN
        if (rd_lock_valid && (n == rd_lock_idx)) n = wrap_inc(n);
`endif
        return n;
    endfunction

    assign buf_base  = buffer_base + ADDR_WIDTH'(idx) * buffer_stride;
    assign line_step = ADDR_WIDTH'(w_lat) * ADDR_WIDTH'(BYTES);
    assign last_beat = (17'(beat) + 17'd1) == {1'b0, w_lat};
    assign last_line = (17'(line) + 17'd1) == {1'b0, h_lat};
    assign sof_seen  = s_axis_tvalid && s_axis_tuser;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            beat  <= '0;
            line  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            beat  <= beat_n;
            line  <= line_n;
        end
    end

    always_ff @(posedge clk) begin
        w_lat     <= w_n;
        h_lat     <= h_n;
        line_addr <= addr_n;
    end

    always_comb begin
        state_n         = state;
        idx_n           = idx;
        beat_n          = beat;
        line_n          = line;
        w_n             = w_lat;
        h_n             = h_lat;
        addr_n          = line_addr;
        s_axis_tready   = 1'b0;
        wr_start        = 1'b0;
        wr_addr         = '0;
        wr_len          = '0;
        wr_data         = '0;
        wr_strb         = '1;
        wr_valid        = 1'b0;
        wr_last         = 1'b0;
        frame_ready     = 1'b0;
        frame_idx       = '0;
        frame_base_addr = '0;
        err_short_line  = 1'b0;
        err_long_line   = 1'b0;
        err_sof         = 1'b0;

        case (state)
            S_IDLE: begin
                // The SOF beat is held back so it becomes beat 0 of the first burst.
                s_axis_tready = !sof_seen;
                if (sof_seen && (frame_width != 16'd0) && (frame_height != 16'd0)) begin
                    w_n     = frame_width;
                    h_n     = frame_height;
                    line_n  = '0;
                    beat_n  = '0;
                    addr_n  = buf_base;
                    state_n = S_LINE_START;
                end
            end
            S_LINE_START: begin
                if ((line != '0) && sof_seen) begin
                    err_sof = 1'b1;
                    line_n  = '0;
                    addr_n  = buf_base;
                end else begin
                    wr_start = 1'b1;
                    wr_addr  = line_addr;
                    wr_len   = w_lat;
                    beat_n   = '0;
                    state_n  = S_STREAM;
                end
            end
            S_STREAM: begin
                wr_valid      = s_axis_tvalid;
                wr_data       = s_axis_tdata;
                wr_last       = last_beat;
                s_axis_tready = wr_ready;
                if (s_axis_tvalid && wr_ready) begin
                    if (last_beat) begin
                        beat_n = '0;
                        if (s_axis_tlast) begin
                            state_n = S_LINE_END;
                        end else begin
                            err_long_line = 1'b1;
                            state_n       = S_DROP;
                        end
                    end else begin
                        beat_n = beat + 1'b1;
                        if (s_axis_tlast) begin
                            err_short_line = 1'b1;
                            state_n        = S_PAD;
                        end
                    end
                end
            end
            S_PAD: begin
                wr_valid = 1'b1;
                wr_strb  = '0;
                wr_last  = last_beat;
                if (wr_ready) begin
                    if (last_beat) begin
                        beat_n  = '0;
                        state_n = S_LINE_END;
                    end else begin
                        beat_n = beat + 1'b1;
                    end
                end
            end
            S_DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) state_n = S_LINE_END;
            end
            S_LINE_END: begin
                line_n  = line + 1'b1;
                addr_n  = line_addr + line_step;
                state_n = last_line ? S_DONE : S_LINE_START;
            end
            S_DONE: begin
                frame_ready     = 1'b1;
                frame_idx       = idx;
                frame_base_addr = buf_base;
                idx_n           = next_idx(idx);
                state_n         = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        if (rst) s_axis_tready = 1'b0;
    end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Bench for frame_buffer_writer: frame table plus hand-written corner sequences,
// write bursts and frame announcements checked against a queue scoreboard.
module tb_frame_buffer_writer;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NB = 3;
    localparam int IW = $clog2(NB);

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_lock_valid;
    logic [IW-1:0] rd_lock_idx;
    logic [15:0]   frame_width, frame_height;
    logic [AW-1:0] buffer_base, buffer_stride;
    logic [DW-1:0] tdata;
    logic          tvalid, tlast, tuser, tready;
    logic          wr_start, wr_valid, wr_last, wr_ready;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_len;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_strb;
    logic          frame_ready;
    logic [IW-1:0] frame_idx;
    logic [AW-1:0] frame_base_addr;
    logic          err_short_line, err_long_line, err_sof;

    always #5 clk = ~clk;

    frame_buffer_writer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BUFFERS(NB), .MAX_WIDTH(1280), .MAX_HEIGHT(720)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef FRAME_BUFFER_WRITER_LOCK_EN
        .rd_lock_valid(rd_lock_valid),
        .rd_lock_idx(rd_lock_idx),
`endif
        .frame_width(frame_width),
        .frame_height(frame_height),
        .buffer_base(buffer_base),
        .buffer_stride(buffer_stride),
        .s_axis_tdata(tdata),
        .s_axis_tvalid(tvalid),
        .s_axis_tlast(tlast),
        .s_axis_tuser(tuser),
        .s_axis_tready(tready),
        .wr_start(wr_start),
        .wr_addr(wr_addr),
        .wr_len(wr_len),
        .wr_data(wr_data),
        .wr_strb(wr_strb),
        .wr_valid(wr_valid),
        .wr_last(wr_last),
        .wr_ready(wr_ready),
        .frame_ready(frame_ready),
        .frame_idx(frame_idx),
        .frame_base_addr(frame_base_addr),
        .err_short_line(err_short_line),
        .err_long_line(err_long_line),
        .err_sof(err_sof)
    );

    typedef struct { logic [31:0] addr; logic [15:0] len; } start_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } beat_t;
    typedef struct { logic [IW-1:0] idx; logic [31:0] base; } frm_t;
    typedef struct {
        int w; int h; int bad_line; int bad_len; bit tog;
        int exp_idx; logic [31:0] exp_base; int exp_short; int exp_long;
    } vec_t;

    start_t sq[$];
    beat_t  bq[$];
    frm_t   fq[$];
    vec_t   vt[8];
    int     n_vec = 0;
    int     n_mis = 0;
    int     n_short, n_long, n_sof;
    bit     mon_en = 1'b0;
    bit     toggle = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic spurious(input string name);
        n_vec++;
        n_mis++;
        $display("FAIL %s: DUT produced an output with nothing expected", name);
    endtask

    function automatic logic [31:0] mkdata(input int tag, input int j, input int k);
        return {8'hA5, 8'(tag), 8'(j), 8'(k)};
    endfunction

    task automatic monitor();
        start_t s;
        beat_t  b;
        frm_t   f;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (wr_start) begin
                    if (sq.size() == 0) spurious("wr_start");
                    else begin
                        s = sq.pop_front();
                        chk("wr_addr", 64'(wr_addr), 64'(s.addr));
                        chk("wr_len", 64'(wr_len), 64'(s.len));
                    end
                end
                if (wr_valid && wr_ready) begin
                    if (bq.size() == 0) spurious("wr_valid beat");
                    else begin
                        b = bq.pop_front();
                        chk("wr_data", 64'(wr_data), 64'(b.data));
                        chk("wr_strb", 64'(wr_strb), 64'(b.strb));
                        chk("wr_last", 64'(wr_last), 64'(b.last));
                    end
                end
                if (frame_ready) begin
                    if (fq.size() == 0) spurious("frame_ready");
                    else begin
                        f = fq.pop_front();
                        chk("frame_idx", 64'(frame_idx), 64'(f.idx));
                        chk("frame_base_addr", 64'(frame_base_addr), 64'(f.base));
                    end
                end
                if (err_short_line) n_short++;
                if (err_long_line) n_long++;
                if (err_sof) n_sof++;
            end
        end
    endtask

    task automatic ready_gen();
        forever begin
            @(posedge clk);
            #1;
            wr_ready = toggle ? ~wr_ready : 1'b1;
        end
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic u, input logic l);
        bit hs;
        int cyc;
        tdata  = d;
        tuser  = u;
        tlast  = l;
        tvalid = 1'b1;
        cyc    = 0;
        hs     = 1'b0;
        do begin
            @(negedge clk);
            hs = tready;
            @(posedge clk);
            #1;
            cyc++;
        end while (!hs && cyc < 300);
        if (!hs) begin
            n_vec++;
            n_mis++;
            $display("FAIL beat handshake: tready stayed 0 for %0d cycles, required 1", cyc);
        end
    endtask

    // Drives nl lines of a w x h frame; the frame announcement is expected only if all lines are sent.
    task automatic send_frame(input int w, input int h, input int nl, input int bad_line,
                              input int bad_len, input int exp_idx, input logic [31:0] exp_base,
                              input int tag);
        int n;
        frame_width  = 16'(w);
        frame_height = 16'(h);
        for (int j = 0; j < nl; j++) begin
            n = (j == bad_line) ? bad_len : w;
            sq.push_back('{32'(exp_base + 32'(j * w * 4)), 16'(w)});
            for (int k = 0; k < w; k++) begin
                if (k < n) bq.push_back('{mkdata(tag, j, k), 4'hF, (k == w - 1)});
                else       bq.push_back('{32'd0, 4'h0, (k == w - 1)});
            end
            for (int k = 0; k < n; k++)
                drive_beat(mkdata(tag, j, k), (j == 0 && k == 0), (k == n - 1));
        end
        tvalid = 1'b0;
        tuser  = 1'b0;
        tlast  = 1'b0;
        if (nl == h) fq.push_back('{IW'(exp_idx), exp_base});
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((sq.size() + bq.size() + fq.size()) != 0 && c < 500) begin
            @(posedge clk);
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard drained", 64'(sq.size() + bq.size() + fq.size()), 64'd0);
    endtask

    initial begin
        vt[0] = '{4, 3, -1, 0, 1'b0, 0, 32'h1000, 0, 0};
        vt[1] = '{4, 3, -1, 0, 1'b0, 1, 32'h1100, 0, 0};
        vt[2] = '{4, 3, -1, 0, 1'b0, 2, 32'h1200, 0, 0};
        vt[3] = '{4, 3, -1, 0, 1'b1, 0, 32'h1000, 0, 0};
        vt[4] = '{4, 3,  1, 2, 1'b0, 1, 32'h1100, 1, 0};
        vt[5] = '{4, 3,  1, 6, 1'b1, 2, 32'h1200, 0, 1};
        vt[6] = '{2, 2, -1, 0, 1'b0, 0, 32'h1000, 0, 0};
        vt[7] = '{1, 1, -1, 0, 1'b0, 1, 32'h1100, 0, 0};

        rst = 1'b1;
        rd_lock_valid = 1'b0;
        rd_lock_idx   = '0;
        frame_width   = 16'd4;
        frame_height  = 16'd3;
        buffer_base   = 32'h1000;
        buffer_stride = 32'h100;
        tdata = '0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
        wr_ready = 1'b1;
        n_short = 0; n_long = 0; n_sof = 0;
        fork
            monitor();
            ready_gen();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset wr_valid", 64'(wr_valid), 64'd0);
        chk("reset wr_start", 64'(wr_start), 64'd0);
        chk("reset frame_ready", 64'(frame_ready), 64'd0);
        chk("reset wr_strb", 64'(wr_strb), 64'hF);
        chk("reset tready", 64'(tready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Frame table
        for (int i = 0; i < 8; i++) begin
            toggle = vt[i].tog;
            n_short = 0;
            n_long  = 0;
            send_frame(vt[i].w, vt[i].h, vt[i].h, vt[i].bad_line, vt[i].bad_len,
                       vt[i].exp_idx, vt[i].exp_base, i);
            drain();
            chk("err_short_line count", 64'(n_short), 64'(vt[i].exp_short));
            chk("err_long_line count", 64'(n_long), 64'(vt[i].exp_long));
        end
        toggle = 1'b0;

        // SOF arriving at the start of line 2: frame restarts in the same buffer
        n_sof = 0;
        n_short = 0;
        send_frame(4, 3, 2, -1, 0, 2, 32'h1200, 20);
        send_frame(4, 3, 3, -1, 0, 2, 32'h1200, 21);
        drain();
        chk("err_sof count", 64'(n_sof), 64'd1);
        chk("err_short after sof", 64'(n_short), 64'd0);

        // Zero width: SOF held off in IDLE until the width becomes nonzero
        frame_width  = 16'd0;
        frame_height = 16'd1;
        tdata = 32'hDEAD_0000; tvalid = 1'b1; tuser = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("zero width tready", 64'(tready), 64'd0);
            chk("zero width wr_start", 64'(wr_start), 64'd0);
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0; tuser = 1'b0;
        send_frame(4, 1, 1, -1, 0, 0, 32'h1000, 30);
        drain();

        // Throttled write port, then reset in the middle of a line
        mon_en = 1'b0;
        toggle = 1'b1;
        frame_width  = 16'd8;
        frame_height = 16'd2;
        tdata = 32'h1234_5678; tvalid = 1'b1; tuser = 1'b1; tlast = 1'b0;
        repeat (3) @(posedge clk);
        repeat (4) begin
            @(negedge clk);
            chk("tready mirrors wr_ready", 64'(tready), 64'(wr_ready));
            chk("stream wr_valid", 64'(wr_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tvalid = 1'b0; tuser = 1'b0;
        @(posedge clk);
        #1;
        chk("mid-line reset wr_valid", 64'(wr_valid), 64'd0);
        chk("mid-line reset wr_last", 64'(wr_last), 64'd0);
        chk("mid-line reset wr_start", 64'(wr_start), 64'd0);
        chk("mid-line reset wr_addr", 64'(wr_addr), 64'd0);
        chk("mid-line reset wr_strb", 64'(wr_strb), 64'hF);
        chk("mid-line reset frame_ready", 64'(frame_ready), 64'd0);
        rst = 1'b0;
        toggle = 1'b0;
        @(posedge clk);
        #1;
        sq.delete(); bq.delete(); fq.delete();
        n_short = 0; n_long = 0; n_sof = 0;
        mon_en = 1'b1;

`ifdef FRAME_BUFFER_WRITER_LOCK_EN
        rd_lock_valid = 1'b1;
        rd_lock_idx   = IW'(1);
        send_frame(4, 2, 2, -1, 0, 0, 32'h1000, 40);
        drain();
        rd_lock_valid = 1'b0;
        send_frame(4, 1, 1, -1, 0, 2, 32'h1200, 41);
        drain();
`else
        send_frame(4, 2, 2, -1, 0, 0, 32'h1000, 40);
        drain();
        send_frame(4, 1, 1, -1, 0, 1, 32'h1100, 41);
        drain();
`endif
        chk("errors after reset", 64'(n_short + n_long + n_sof), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
